// File: rtl/dcache_wt_system.sv
// dcache_wt_system: direct-mapped write-through data cache with line refill, multi-cycle backing memory and controller FSM.
// Define DCACHE_STATS_EN to add the saturating hit_count/miss_count read statistics.
module dcache_wt_system #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int LINES          = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LATENCY    = 4,
    parameter int STAT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] DataIn,
    output logic              Stall,
    output logic [DATA_W-1:0] DataOut
`ifdef DCACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    if (LINES < 2 || WORDS_PER_LINE < 2 || MEM_LATENCY < 1 || STAT_W < 1 || TAG_W < 1) begin : g_bad_cfg
        $error("dcache_wt_system: unsupported geometry");
    end

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] mem      [2**ADDR_W];
    logic [DATA_W-1:0] data_arr [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [LINES-1:0]  valid;
    logic [LAT_W-1:0]  lat_cnt;
    logic [OFF_W-1:0]  word_cnt;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             rd, hit, lat_end, last_word;
    logic [DATA_W-1:0] cached;

    assign {tag, idx, off} = mem_address;
    assign rd        = MemRead && !MemWrite;
    assign hit       = valid[idx] && tag_arr[idx] == tag;
    assign lat_end   = lat_cnt == LAT_W'(MEM_LATENCY - 1);
    assign last_word = word_cnt == OFF_W'(WORDS_PER_LINE - 1);
    assign cached    = data_arr[{idx, off}];

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state, stall and read data; IDLE hits answer without stalling
    always_comb begin
        state_nx = state;
        Stall    = 1'b0;
        DataOut  = '0;
        unique case (state)
            IDLE: begin
                if (MemWrite) begin
                    Stall    = 1'b1;
                    state_nx = WRITE;
                end else if (MemRead && hit) begin
                    DataOut = cached;
                end else if (MemRead) begin
                    Stall    = 1'b1;
                    state_nx = FILL;
                end
            end
            FILL: begin
                Stall    = 1'b1;
                state_nx = (lat_end && last_word) ? DONE : FILL;
            end
            WRITE: begin
                Stall    = 1'b1;
                state_nx = lat_end ? DONE : WRITE;
            end
            DONE: begin
                DataOut  = rd ? cached : '0;
                state_nx = IDLE;
            end
        endcase
    end

    // valid bits, latency/word counters and the backing memory with its write-through commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= '0;
            lat_cnt  <= '0;
            word_cnt <= '0;
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else begin
            if (state == IDLE && rd && !hit) valid[idx] <= 1'b0;
            if (state == FILL || state == WRITE) lat_cnt <= lat_end ? '0 : lat_cnt + 1'b1;
            if (state == FILL && lat_end) begin
                word_cnt <= word_cnt + 1'b1;
                if (last_word) valid[idx] <= 1'b1;
            end
            if (state == WRITE && lat_end) mem[mem_address] <= DataIn;
        end
    end

    // cache data/tag arrays: line refill word by word, and in-place update on a write hit
    always_ff @(posedge clk) begin
        if (state == FILL && lat_end) data_arr[{idx, word_cnt}] <= mem[{tag, idx, word_cnt}];
        if (state == FILL && lat_end && last_word) tag_arr[idx] <= tag;
        if (state == WRITE && lat_end && hit) data_arr[{idx, off}] <= DataIn;
    end

`ifdef DCACHE_STATS_EN
    // saturating read hit/miss counters, bumped once per request on its IDLE decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && rd) begin
            if (hit && !(&hit_count)) hit_count <= hit_count + 1'b1;
            if (!hit && !(&miss_count)) miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_wt_system.sv
// tb_dcache_wt_system: directed plus random read/write traffic checked against a line-level cache model.
module tb_dcache_wt_system;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int LINES  = 32;
    localparam int WPL    = 4;
    localparam int LAT    = 4;
    localparam int STAT_W = 16;
    localparam int OFF_W  = $clog2(WPL);
    localparam int IDX_W  = $clog2(LINES);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic [ADDR_W-1:0] mem_address = '0;
    logic [DATA_W-1:0] DataIn = '0;
    logic              Stall;
    logic [DATA_W-1:0] DataOut;
`ifdef DCACHE_STATS_EN
    logic [STAT_W-1:0] hit_count, miss_count;
`endif

    int checks = 0;
    int fails = 0;
    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    bit                ref_valid [LINES];
    int                ref_tag [LINES];
    int                ref_hits, ref_misses;

    dcache_wt_system #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES),
        .WORDS_PER_LINE(WPL), .MEM_LATENCY(LAT), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_address(mem_address), .DataIn(DataIn), .Stall(Stall), .DataOut(DataOut)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = '0;
        for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
        ref_hits = 0;
        ref_misses = 0;
    endtask

    task automatic check_counts(input string name);
`ifdef DCACHE_STATS_EN
        check({name, "_hits"}, DATA_W'(hit_count), DATA_W'(ref_hits));
        check({name, "_misses"}, DATA_W'(miss_count), DATA_W'(ref_misses));
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    // one request, entered at posedge+1; returns at posedge+1 after the request retires
    task automatic access(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int li, tg, exp_stall, n;
        bit rd, hit;
        logic [DATA_W-1:0] exp_out;
        li = int'(a >> OFF_W) % LINES;
        tg = int'(a >> (OFF_W + IDX_W));
        rd = r && !w;
        hit = rd && ref_valid[li] && ref_tag[li] == tg;
        exp_stall = w ? 1 + LAT : (rd && !hit) ? 1 + WPL * LAT : 0;
        exp_out = rd ? ref_mem[a] : '0;
        MemRead = r;
        MemWrite = w;
        mem_address = a;
        DataIn = d;
        n = 0;
        @(negedge clk);
        while (Stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("stall_cycles r%0d w%0d @%h", r, w, a), DATA_W'(n), DATA_W'(exp_stall));
        check($sformatf("dataout r%0d w%0d @%h", r, w, a), DataOut, exp_out);
        if (w) ref_mem[a] = d;
        else if (rd && hit) ref_hits++;
        else if (rd) begin
            ref_misses++;
            ref_valid[li] = 1'b1;
            ref_tag[li] = tg;
        end
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        check_counts($sformatf("counts @%h", a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_stall", DATA_W'(Stall), '0);
        check("reset_dataout", DataOut, '0);
        rst = 1'b0;
        check_counts("reset");
        @(posedge clk);
        #1;
        access(1'b0, 1'b0, 12'h010, '0);
        access(1'b1, 1'b0, 12'h010, '0);
        access(1'b0, 1'b1, 12'h020, 32'hDEADBEEF);
        access(1'b1, 1'b0, 12'h020, '0);
        access(1'b1, 1'b0, 12'h021, '0);
        access(1'b0, 1'b1, 12'h022, 32'h12345678);
        access(1'b1, 1'b0, 12'h022, '0);
        access(1'b1, 1'b0, 12'h020, '0);
        access(1'b1, 1'b0, 12'h420, '0);
        access(1'b1, 1'b0, 12'h020, '0);
        access(1'b1, 1'b0, 12'h420, '0);
        // reset on the 8th stalled cycle of a refill
        MemRead = 1'b1;
        mem_address = 12'h030;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (Stall) n++;
        end
        check("prereset_stall_cycles", DATA_W'(n), 32'd8);
        rst = 1'b1;
        MemRead = 1'b0;
        #1;
        check("midfill_reset_stall", DATA_W'(Stall), '0);
        check("midfill_reset_dataout", DataOut, '0);
        model_reset();
        check_counts("midfill_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 12'h030, '0);
        access(1'b1, 1'b0, 12'h031, '0);
        access(1'b1, 1'b1, 12'h040, 32'hA5A5A5A5);
        access(1'b1, 1'b0, 12'h040, '0);
        for (int i = 0; i < 80; i++) begin
            int op;
            logic [ADDR_W-1:0] a;
            op = int'($urandom_range(0, 9));
            a = ADDR_W'(($urandom_range(0, 1) << 10) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            access(op < 5 || op == 8, op >= 5 && op <= 8, a, $urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
